pe_r_seq: RTL and testbench
===========================

// Module: pe_r_seq
// PURPOSE
//  Sequencer for one reconfigurable PE (GEMM / DIV / EXP / LOG modes). Accepts one op command at a
//  time, holds the PE mode stable for the whole op, and gates the operand stream into the PE.
//  Tracks PE pipeline latency so out_valid/out_last mark exactly the PE result beats. Signals done
//  once the PE pipeline has drained, so the mode never changes while results are in flight.
//  Sits between the array scheduler (command + operand source) and the PE's mode/operand inputs.
// PARAMETERS
//  LEN_BW    8  width of cmd_len (beats per op)
//  GEMM_LAT  2  cycles from accepted GEMM beat to PE result valid (1..8)
//  UNO_LAT   2  cycles from accepted DIV/EXP/LOG beat to PE result valid (1..8)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous reset, active low
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op       in   2       00 gemm, 01 div, 10 exp, 11 log
//  cmd_len      in   LEN_BW  number of operand beats; 0 = empty op
//  in_valid     in   1       operand beat present on PE x/wc inputs
//  in_ready     out  1       beat consumed when in_valid & in_ready
//  pe_gemm_uno  out  2       mode to PE
//  pe_beat      out  1       = in_valid & in_ready (beat-qualifier for the PE array)
//  out_valid    out  1       PE output holds a result of the current op
//  out_last     out  1       with out_valid: final result of the op
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse: op complete, pipeline empty
// BEHAVIOUR
//  Reset (async): state IDLE; pe_gemm_uno=00; cmd_ready=1; in_ready, out_valid, out_last, busy,
//   done = 0; beat counter and valid delay line cleared. A reset mid-op discards all pending state.
//  States: IDLE, RUN, DRAIN.
//   IDLE: cmd_ready=1. On accept: latch op into mode reg (pe_gemm_uno updates next cycle), latch
//    len, select LAT = (op==00)?GEMM_LAT:UNO_LAT. len!=0 -> RUN; len==0 -> IDLE, done pulses the
//    following cycle, no out_valid.
//   RUN: in_ready=1. Each accepted beat increments beat counter; accepting beat len -> DRAIN.
//    in_valid gaps allowed: no beat consumed, counter holds, no out_valid bubble filled.
//   DRAIN: in_ready=0; wait until delay line empty -> IDLE with done=1 (registered, visible in
//    first IDLE cycle). A command may be accepted in that same cycle.
//  cmd_ready = (state==IDLE); commands offered while busy are not accepted (held by sender).
//  pe_gemm_uno: changes only on command accept; held through RUN, DRAIN and following IDLE.
//  Latency: beat accepted in cycle t -> out_valid=1 in cycle t+LAT; out_last=1 alongside the
//   out_valid of the len-th beat. Delay line: MAX_LAT-deep shift of {valid,last}, tap LAT.
//  No output backpressure: PE result registers overwrite every cycle; consumer must take
//   out_valid beats as they appear.
//  Beat counter LEN_BW bits, compared for equality with len; never wraps (max len = 2^LEN_BW-1).
//  done and cmd accept in same cycle: new op starts normally; done refers to the previous op.
// STRUCTURE
//  Shared package raven_pe_pkg: typedef enum logic[1:0] pe_op_e {OP_GEMM, OP_DIV, OP_EXP,
//   OP_LOG}; typedef enum seq_state_e {IDLE, RUN, DRAIN}; localparam MAX_LAT = 8.
//  Sub-module pe_vld_pipe: MAX_LAT-stage {valid,last} shift register with runtime tap select and
//   empty flag; rest (FSM, counter, mode reg) inline.
// TESTING
//  GEMM len=4, in_valid continuous from t0 -> in_ready 4 cycles, out_valid t0+2..t0+5,
//   out_last at t0+5, done at t0+6, pe_gemm_uno=00 throughout.
//  EXP len=3, in_valid pattern 1,0,1,1 -> 3 beats consumed, out_valid pattern 1,0,1,1 shifted by
//   UNO_LAT, out_last on third result, pe_gemm_uno=10 from cycle after accept.
//  DIV len=0 -> no in_ready, no out_valid, done pulse 1 cycle after accept, back in IDLE.
//  LOG len=2 then cmd_valid held during RUN with op GEMM -> second cmd accepted only in done
//   cycle; pe_gemm_uno stays 11 until then, becomes 00 next cycle.
//  Reset asserted in RUN after 2 of 5 beats -> all outputs reset value immediately; no out_valid
//   or done after release; next command starts cleanly.
//  GEMM_LAT=1, UNO_LAT=3 build: back-to-back GEMM then LOG ops -> no overlap of result beats,
//   each out_last exact.

Source files
------------

// File: rtl/raven_pe_pkg.sv
// Shared types and sizing for the reconfigurable PE sequencer.
package raven_pe_pkg;

    typedef enum logic [1:0] {
        OP_GEMM = 2'b00,
        OP_DIV  = 2'b01,
        OP_EXP  = 2'b10,
        OP_LOG  = 2'b11
    } pe_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } seq_state_e;

    localparam int MAX_LAT = 8;
    localparam int IDX_BW  = $clog2(MAX_LAT);
    localparam int TAP_BW  = IDX_BW + 1;

endpackage

// File: rtl/pe_vld_pipe.sv
// Valid/last delay line mirroring the PE pipeline, with a runtime latency tap
// and a flag telling whether any result is still to appear at the tap.
module pe_vld_pipe
    import raven_pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [TAP_BW-1:0] tap,
    output logic              out_valid,
    output logic              out_last,
    output logic              pending
);

    logic [MAX_LAT-1:0] valid_q;
    logic [MAX_LAT-1:0] last_q;
    logic [MAX_LAT-1:0] early;
    logic [IDX_BW-1:0]  tap_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            last_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= {valid_q[MAX_LAT-2:0], in_valid};
            last_q  <= {last_q[MAX_LAT-2:0], in_valid & in_last};
        end
    end

    // Stage i surfaces at the tap after tap-1-i more cycles; only stages
    // strictly before the tap still hold results that have not been shown.
    generate
        for (genvar gi = 0; gi < MAX_LAT; gi++) begin : g_early
            assign early[gi] = valid_q[gi] && (TAP_BW'(gi + 1) < tap);
        end
    endgenerate

    assign pending   = |early;
    assign tap_idx   = IDX_BW'(tap - 1'b1);
    assign out_valid = valid_q[tap_idx];
    assign out_last  = last_q[tap_idx];

endmodule

// File: rtl/pe_r_seq.sv
// Op sequencer for one reconfigurable PE: holds the mode for a whole op, gates
// operand beats, marks result beats and pulses done once the pipeline drains.
module pe_r_seq
    import raven_pe_pkg::*;
#(
    parameter int LEN_BW   = 8,
    parameter int GEMM_LAT = 2,
    parameter int UNO_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_BW-1:0] cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        pe_gemm_uno,
    output logic              pe_beat,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [TAP_BW-1:0] GEMM_TAP = TAP_BW'(GEMM_LAT);
    localparam logic [TAP_BW-1:0] UNO_TAP  = TAP_BW'(UNO_LAT);

    seq_state_e        state_q, state_d;
    pe_op_e            mode_q, mode_d;
    logic [LEN_BW-1:0] len_q, len_d;
    logic [LEN_BW-1:0] cnt_q, cnt_d;
    logic [LEN_BW-1:0] cnt_inc;
    logic [TAP_BW-1:0] lat_q, lat_d;
    logic              done_q, done_d;
    logic              flush;
    logic              last_beat;
    logic              pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= OP_GEMM;
            len_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= GEMM_TAP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        done_d    = 1'b0;
        flush     = 1'b0;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    mode_d = pe_op_e'(cmd_op);
                    len_d  = cmd_len;
                    lat_d  = (pe_op_e'(cmd_op) == OP_GEMM) ? GEMM_TAP : UNO_TAP;
                    cnt_d  = '0;
                    // Previous op has fully drained; clear leftovers so a
                    // longer new latency cannot re-expose old beats.
                    flush  = 1'b1;
                    if (cmd_len != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pe_beat   = in_valid & in_ready;
    assign last_beat = (cnt_inc == len_q);

    pe_vld_pipe u_vld_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (pe_beat),
        .in_last   (last_beat),
        .tap       (lat_q),
        .out_valid (out_valid),
        .out_last  (out_last),
        .pending   (pending)
    );

    assign pe_gemm_uno = mode_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_pe_r_seq.sv
// Bench for pe_r_seq: two builds (latencies 2/2 and 1/3) driven with shared
// stimulus, checked cycle by cycle against a per-op timeline model.
module tb_pe_r_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       in_valid;

    logic       a_cmd_ready, a_in_ready, a_pe_beat, a_out_valid, a_out_last, a_busy, a_done;
    logic [1:0] a_mode;
    logic       b_cmd_ready, b_in_ready, b_pe_beat, b_out_valid, b_out_last, b_busy, b_done;
    logic [1:0] b_mode;

    bit         sel_b = 1'b0;
    logic [8:0] obs;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_r_seq #(.LEN_BW(8), .GEMM_LAT(2), .UNO_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .in_valid(in_valid), .in_ready(a_in_ready),
        .pe_gemm_uno(a_mode), .pe_beat(a_pe_beat), .out_valid(a_out_valid),
        .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );

    pe_r_seq #(.LEN_BW(8), .GEMM_LAT(1), .UNO_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .in_valid(in_valid), .in_ready(b_in_ready),
        .pe_gemm_uno(b_mode), .pe_beat(b_pe_beat), .out_valid(b_out_valid),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    // Observed vector: {cmd_ready, in_ready, pe_beat, out_valid, out_last, busy, done, mode}
    assign obs = sel_b ? {b_cmd_ready, b_in_ready, b_pe_beat, b_out_valid, b_out_last, b_busy, b_done, b_mode}
                       : {a_cmd_ready, a_in_ready, a_pe_beat, a_out_valid, a_out_last, a_busy, a_done, a_mode};

    // Entry: just after the negedge of the cycle in which the command is offered.
    // Exit: just after the negedge of the done cycle (next command may go there).
    // mode: 0 continuous in_valid, 1 fixed pattern, 2 random.
    task automatic run_op(input int op, input int len, input int mode, input logic [15:0] pat,
                          input bit hold, input int hold_op, input int hold_len);
        int lat, acc, beats, lastbeat, done_cyc, c, idx;
        int beat_cyc[$];
        bit exp_ir, exp_ov, exp_ol, exp_done, exp_busy, reached;
        logic [8:0] exp_v;
        if (sel_b) lat = (op == 0) ? 1 : 3;
        else       lat = 2;
        acc = cyc;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_len   = 8'(len);
        in_valid  = 1'($urandom_range(0, 1));
        #1;
        n_chk++;
        if (obs[8] !== 1'b1 || obs[7] !== 1'b0) begin
            $display("FAIL accept_ready cyc=%0d op=%0d got cmd_ready=%b in_ready=%b required 1 0", acc, op, obs[8], obs[7]);
        end else n_pass++;
        beats = 0; lastbeat = -1; idx = 0; reached = 1'b0;
        done_cyc = (len == 0) ? acc + 1 : -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            c = cyc;
            cmd_valid = hold;
            if (hold) begin
                cmd_op  = 2'(hold_op);
                cmd_len = 8'(hold_len);
            end
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (idx < 16) ? pat[idx] : 1'b0;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            idx++;
            #1;
            exp_ir = (len > 0) && (beats < len);
            if (exp_ir && in_valid) begin
                beats++;
                beat_cyc.push_back(c);
                if (beats == len) begin
                    lastbeat = c;
                    done_cyc = c + lat + 1;
                end
            end
            exp_ov = 1'b0;
            foreach (beat_cyc[i]) if (beat_cyc[i] == c - lat) exp_ov = 1'b1;
            exp_ol   = (lastbeat >= 0) && (c - lat == lastbeat);
            exp_done = (c == done_cyc);
            exp_busy = (done_cyc < 0) || (c < done_cyc);
            exp_v = {!exp_busy, exp_ir, exp_ir & in_valid, exp_ov, exp_ol, exp_busy, exp_done, 2'(op)};
            n_chk++;
            if (obs !== exp_v) begin
                $display("FAIL op_cycle dut=%s op=%0d len=%0d rel=%0d got {cr,ir,beat,ov,ol,busy,done,mode}=%b required %b",
                         sel_b ? "B" : "A", op, len, c - acc, obs, exp_v);
            end else n_pass++;
            if (c == done_cyc) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) begin
            n_chk++;
            $display("FAIL op_timeout op=%0d len=%0d got no done within bound required done", op, len);
        end
        $display("op dut=%s op=%0d len=%0d accept=%0d done=%0d", sel_b ? "B" : "A", op, len, acc, done_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 8'd0; in_valid = 1'b0;
        #3;
        n_chk++;
        if (obs !== 9'b1_0000_0000) $display("FAIL reset_state got %b required %b", obs, 9'b1_0000_0000);
        else n_pass++;
        cmd_valid = 1'b1; cmd_len = 8'd3; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (obs !== 9'b1_0000_0000) $display("FAIL reset_hold got %b required %b", obs, 9'b1_0000_0000);
        else n_pass++;
        cmd_valid = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_gemm_basic();
        @(negedge clk); #1;
        run_op(0, 4, 0, 16'h0, 1'b0, 0, 0);
    endtask

    task automatic test_exp_gaps();
        run_op(2, 3, 1, 16'b1101, 1'b0, 0, 0);
    endtask

    task automatic test_div_empty();
        run_op(1, 0, 2, 16'h0, 1'b0, 0, 0);
    endtask

    task automatic test_held_cmd();
        run_op(3, 2, 0, 16'h0, 1'b1, 0, 3);
        run_op(0, 3, 2, 16'h0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 8'd5; in_valid = 1'b0;
        @(negedge clk); cmd_valid = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (obs !== 9'b0_1110_1000) $display("FAIL pre_reset got %b required %b", obs, 9'b0_1110_1000);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 9'b1_0000_0000) $display("FAIL mid_reset got %b required %b", obs, 9'b1_0000_0000);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            n_chk++;
            if (obs !== 9'b1_0000_0000) $display("FAIL post_reset i=%0d got %b required %b", i, obs, 9'b1_0000_0000);
            else n_pass++;
        end
        $display("test_reset_mid_op done");
        run_op(2, 2, 0, 16'h0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 2, 16'h0, 1'b0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst_n = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
        sel_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        run_op(0, 4, 0, 16'h0, 1'b0, 0, 0);
        run_op(3, 4, 0, 16'h0, 1'b0, 0, 0);
        run_op(0, 3, 2, 16'h0, 1'b0, 0, 0);
        run_op(1, 0, 2, 16'h0, 1'b0, 0, 0);
        run_op(2, 5, 2, 16'h0, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 2, 16'h0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_gemm_basic();
        test_exp_gaps();
        test_div_empty();
        test_held_cmd();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
